// File: rtl/xum_pkg.sv
// xum_pkg
// Shared definitions for the channel scan multiplexer slice.
//   state_t     : controller state (direct selection or autonomous scan)
//   MODE_DIRECT : value of the MODE input that selects direct mode
//   MODE_SCAN   : value of the MODE input that selects scan mode
//   sel_width() : clog2-based width helper, never narrower than one bit
package xum_pkg;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // A counter or select for n values needs clog2(n) bits, but a vector
  // cannot be zero bits wide, so n = 1 still gets a single bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_mux.sv
// chan_mux
// Purely combinational N:1 selector of W-bit channels.
// Ports:
//   data : N*W flattened channels, channel k at data[k*W +: W]
//   sel  : channel index; values >= N select nothing
//   y    : selected channel, or all zeros for an out-of-range select
module chan_mux
  import xum_pkg::*;
#(
  parameter int W  = 1,
  parameter int N  = 8,
  parameter int SW = sel_width(N)
) (
  input  logic [N*W-1:0] data,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   y
);

  // Walk every real channel and pick the one whose index matches. When sel
  // points past the last channel nothing matches and the zero default stays,
  // which is what lets N be a non-power-of-two.
  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SW'(k)) begin
        y = data[k*W +: W];
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux
// Registered N-channel, W-bit selector with a one-entry valid/ready output
// slot and an autonomous scan mode that visits every channel in turn,
// spending DWELL enabled cycles on each before emitting its sample.
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous active-high reset
//   I     : N*W flattened channel inputs, channel k at I[k*W +: W]
//   S     : channel select used in direct mode
//   MODE  : 0 = direct, 1 = scan (state follows one cycle later)
//   EN    : capture enable
//   Y     : registered sample
//   CH    : channel index of the sample on Y
//   VALID : Y/CH hold an unconsumed sample
//   READY : consumer accepts when VALID && READY
//   WRAP  : one-cycle pulse alongside a scan load of channel N-1
module chan_scan_mux
  import xum_pkg::*;
#(
  parameter  int W     = 1,
  parameter  int N     = 8,
  parameter  int DWELL = 1,
  localparam int SW    = sel_width(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N*W-1:0] I,
  input  logic [SW-1:0]  S,
  input  logic           MODE,
  input  logic           EN,
  output logic [W-1:0]   Y,
  output logic [SW-1:0]  CH,
  output logic           VALID,
  input  logic           READY,
  output logic           WRAP
);

  localparam int CW = sel_width(DWELL);

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [SW-1:0] mux_sel;
  logic [W-1:0]  mux_y;
  logic          slot_free;
  logic          load;
  logic          wrap_next;

  // A single selector serves both modes; only its select source changes.
  chan_mux #(
    .W  (W),
    .N  (N),
    .SW (SW)
  ) u_chan_mux (
    .data (I),
    .sel  (mux_sel),
    .y    (mux_y)
  );

  // State register: the state simply tracks MODE with one cycle of lag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_DIRECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and load decision. Outside scan the pointer and dwell
  // counter are forced to zero, so a fresh entry into scan always starts at
  // channel 0 with a full dwell. At the end of a dwell the counter waits
  // at DWELL-1 until the slot frees up, so a stalled consumer never causes
  // a channel to be skipped.
  always_comb begin
    slot_free  = !VALID || READY;
    state_next = (MODE == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    mux_sel    = S;
    ptr_next   = '0;
    cnt_next   = '0;
    load       = 1'b0;
    wrap_next  = 1'b0;
    case (state)
      ST_DIRECT: begin
        load = EN && slot_free;
      end
      ST_SCAN: begin
        mux_sel  = ptr;
        ptr_next = ptr;
        cnt_next = cnt;
        if (EN) begin
          if (cnt == CW'(DWELL - 1)) begin
            if (slot_free) begin
              load      = 1'b1;
              wrap_next = (ptr == SW'(N - 1));
              ptr_next  = (ptr == SW'(N - 1)) ? '0 : ptr + SW'(1);
              cnt_next  = '0;
            end
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output slot plus scan pointer/counter. A load overwrites the slot even
  // if the old entry is being accepted this cycle; otherwise an accept
  // empties it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Y     <= '0;
      CH    <= '0;
      VALID <= 1'b0;
      WRAP  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      ptr  <= ptr_next;
      cnt  <= cnt_next;
      WRAP <= wrap_next;
      if (load) begin
        Y     <= mux_y;
        CH    <= mux_sel;
        VALID <= 1'b1;
      end else if (READY) begin
        VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux
// Drives two chan_scan_mux instances from shared controls: dut_a with
// N = 8, DWELL = 3 and dut_b with N = 5, DWELL = 2, both W = 4. dut_b sees
// the lower five channels of the same input pattern.
module tb_chan_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        en;
  logic        ready;
  logic [2:0]  sel;
  logic [31:0] i_a;
  logic [19:0] i_b;

  logic [3:0]  y_a;
  logic [2:0]  ch_a;
  logic        valid_a;
  logic        wrap_a;
  logic [3:0]  y_b;
  logic [2:0]  ch_b;
  logic        valid_b;
  logic        wrap_b;

  int checks   = 0;
  int failures = 0;
  int wraps_a  = 0;
  int wraps_b  = 0;
  bit live     = 1'b0;

  // Channel values: ch0=C ch1=1 ch2=2 ch3=A ch4=4 ch5=5 ch6=6 ch7=7
  logic [3:0] vals [8] = '{4'hC, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7};

  typedef struct {
    bit scanning;
    int ptr;
    int cnt;
    int y;
    int ch;
    bit valid;
    bit wrap;
  } mstate_t;

  mstate_t ma = '{default: 0};
  mstate_t mb = '{default: 0};

  always #5 clk = ~clk;

  chan_scan_mux #(.W(4), .N(8), .DWELL(3)) dut_a (
    .CLK(clk), .RST(rst), .I(i_a), .S(sel), .MODE(mode), .EN(en),
    .Y(y_a), .CH(ch_a), .VALID(valid_a), .READY(ready), .WRAP(wrap_a)
  );

  chan_scan_mux #(.W(4), .N(5), .DWELL(2)) dut_b (
    .CLK(clk), .RST(rst), .I(i_b), .S(sel), .MODE(mode), .EN(en),
    .Y(y_b), .CH(ch_b), .VALID(valid_b), .READY(ready), .WRAP(wrap_b)
  );

  // Behaviour of one edge expressed from the channel-scanning rules: direct
  // mode loads the selected channel (zero past the last one), scan mode
  // emits channel ptr after dwell enabled cycles, wrapping modulo n.
  function automatic mstate_t model_next(input mstate_t m, input int n,
                                         input int dwell, input logic [31:0] ins,
                                         input int s, input bit r, input bit md,
                                         input bit e, input bit rd);
    mstate_t nx;
    bit      free;
    nx   = m;
    free = !m.valid || rd;
    if (r) begin
      nx = '{default: 0};
      return nx;
    end
    nx.wrap     = 1'b0;
    nx.scanning = md;
    if (!m.scanning) begin
      nx.ptr = 0;
      nx.cnt = 0;
      if (e && free) begin
        nx.y     = (s < n) ? int'(ins[s*4 +: 4]) : 0;
        nx.ch    = s;
        nx.valid = 1'b1;
      end else if (rd) begin
        nx.valid = 1'b0;
      end
    end else begin
      if (e && free && m.cnt == dwell - 1) begin
        nx.y     = int'(ins[m.ptr*4 +: 4]);
        nx.ch    = m.ptr;
        nx.valid = 1'b1;
        nx.wrap  = (m.ptr == n - 1);
        nx.ptr   = (m.ptr + 1) % n;
        nx.cnt   = 0;
      end else begin
        if (e && m.cnt < dwell - 1) nx.cnt = m.cnt + 1;
        if (rd) nx.valid = 1'b0;
      end
    end
    return nx;
  endfunction

  // Advance both reference models on every rising edge.
  always @(posedge clk) begin
    ma <= model_next(ma, 8, 3, i_a, int'(sel), rst, mode, en, ready);
    mb <= model_next(mb, 5, 2, {12'h000, i_b}, int'(sel), rst, mode, en, ready);
    if (rst) live <= 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge after the first reset, both instances must agree with
  // their models on all outputs.
  always @(negedge clk) begin
    if (live) begin
      checkOutput("model_a_y",     32'(y_a),     32'(ma.y));
      checkOutput("model_a_ch",    32'(ch_a),    32'(ma.ch));
      checkOutput("model_a_valid", 32'(valid_a), 32'(ma.valid));
      checkOutput("model_a_wrap",  32'(wrap_a),  32'(ma.wrap));
      checkOutput("model_b_y",     32'(y_b),     32'(mb.y));
      checkOutput("model_b_ch",    32'(ch_b),    32'(mb.ch));
      checkOutput("model_b_valid", 32'(valid_b), 32'(mb.valid));
      checkOutput("model_b_wrap",  32'(wrap_b),  32'(mb.wrap));
    end
  end

  task automatic applyStimulus(input bit r, input bit md, input bit e,
                               input bit rd, input logic [2:0] s);
    rst   = r;
    mode  = md;
    en    = e;
    ready = rd;
    sel   = s;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkA(input string name, input logic [3:0] y, input logic [2:0] ch,
                        input bit v, input bit w);
    checkOutput({name, "_a_y"},     32'(y_a),     32'(y));
    checkOutput({name, "_a_ch"},    32'(ch_a),    32'(ch));
    checkOutput({name, "_a_valid"}, 32'(valid_a), 32'(v));
    checkOutput({name, "_a_wrap"},  32'(wrap_a),  32'(w));
  endtask

  task automatic checkB(input string name, input logic [3:0] y, input logic [2:0] ch,
                        input bit v, input bit w);
    checkOutput({name, "_b_y"},     32'(y_b),     32'(y));
    checkOutput({name, "_b_ch"},    32'(ch_b),    32'(ch));
    checkOutput({name, "_b_valid"}, 32'(valid_b), 32'(v));
    checkOutput({name, "_b_wrap"},  32'(wrap_b),  32'(w));
  endtask

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    i_a = {4'h7, 4'h6, 4'h5, 4'h4, 4'hA, 4'h2, 4'h1, 4'hC};
    i_b = i_a[19:0];

    // Two cycles of reset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (2) step();
    checkA("reset", 4'h0, 3'd0, 1'b0, 1'b0);
    checkB("reset", 4'h0, 3'd0, 1'b0, 1'b0);

    // Direct select of channel 3
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    step();
    checkA("direct3", 4'hA, 3'd3, 1'b1, 1'b0);
    checkB("direct3", 4'hA, 3'd3, 1'b1, 1'b0);

    // Backpressure: slot held while S moves to 5
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd5);
    step();
    checkA("hold1", 4'hA, 3'd3, 1'b1, 1'b0);
    step();
    checkA("hold2", 4'hA, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd5);
    step();
    checkA("direct5", 4'h5, 3'd5, 1'b1, 1'b0);
    checkB("oor5", 4'h0, 3'd5, 1'b1, 1'b0);

    // Out-of-range select on the five-channel instance
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd6);
    step();
    checkA("direct6", 4'h6, 3'd6, 1'b1, 1'b0);
    checkB("oor6", 4'h0, 3'd6, 1'b1, 1'b0);

    // Scan: the switching edge still performs a direct load of S = 0
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    step();
    checkA("scan_entry", 4'hC, 3'd0, 1'b1, 1'b0);
    checkB("scan_entry", 4'hC, 3'd0, 1'b1, 1'b0);

    for (int j = 1; j <= 27; j++) begin
      step();
      if (wrap_a) wraps_a++;
      if (wrap_b) wraps_b++;
      if (j % 3 == 0) begin
        k = (j / 3 - 1) % 8;
        checkA($sformatf("sweep%0d", j), vals[k], 3'(k), 1'b1, k == 7);
      end else begin
        checkOutput($sformatf("sweep%0d_a_valid", j), 32'(valid_a), 32'd0);
        checkOutput($sformatf("sweep%0d_a_wrap", j),  32'(wrap_a),  32'd0);
      end
      if (j % 2 == 0) begin
        k = (j / 2 - 1) % 5;
        checkB($sformatf("sweep%0d", j), vals[k], 3'(k), 1'b1, k == 4);
      end else begin
        checkOutput($sformatf("sweep%0d_b_valid", j), 32'(valid_b), 32'd0);
        checkOutput($sformatf("sweep%0d_b_wrap", j),  32'(wrap_b),  32'd0);
      end
    end
    checkOutput("wrap_count_a", 32'(wraps_a), 32'd1);
    checkOutput("wrap_count_b", 32'(wraps_b), 32'd2);

    // Run on to the channel-2 load, then stall for five cycles
    repeat (6) step();
    checkA("pend2", 4'h2, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int j = 0; j < 5; j++) begin
      step();
      checkA($sformatf("stall%0d", j), 4'h2, 3'd2, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    step();
    checkA("after_stall", 4'hA, 3'd3, 1'b1, 1'b0);

    // Reset while a sample is pending and ptr = 4, MODE stays high
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    step();
    checkA("mid_reset", 4'h0, 3'd0, 1'b0, 1'b0);
    checkB("mid_reset", 4'h0, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    repeat (4) step();
    checkA("restart0", 4'hC, 3'd0, 1'b1, 1'b0);
    repeat (3) step();
    checkA("restart1", 4'h1, 3'd1, 1'b1, 1'b0);

    // Enable low freezes the scan, then a switch back to direct with a
    // pending sample under backpressure
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
    repeat (4) step();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    repeat (6) step();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
    repeat (4) step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd7);
    repeat (3) step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3'd7);
    repeat (4) step();

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
